enc_block_feeder: RTL and testbench
===================================

ENC_BLOCK_FEEDER -- requirements
Module: enc_block_feeder

Interface
REQ-001 Parameter: BLOCK_LENGTH, default 64, cipher block width in bits; only 64 supported; byte count = BLOCK_LENGTH/8 = 8.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_byte  input  8  plaintext byte, MSB-first order.
REQ-006 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-007 iv_load  input  1  reload CBC chain value from iv.
REQ-008 iv  input  64  CBC initialisation vector.
REQ-009 enc_start  output  1  start pulse to encoder.
REQ-010 enc_p_text  output  64  plaintext block to encoder.
REQ-011 enc_done  input  1  encoder completion pulse.
REQ-012 enc_c_text  input  64  encoder ciphertext, valid while enc_done=1.
REQ-013 out_valid  output  1  ciphertext block available.
REQ-014 out_data  output  64  ciphertext block.
REQ-015 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-016 busy  output  1  high in any state other than COLLECT.

Function
REQ-017 FSM states: COLLECT, START, WAIT, OUTPUT.
REQ-018 COLLECT: in_ready=1; each accepted byte shifts into block register at [63-8k:56-8k], k=byte count 0..7; count increments.
REQ-019 8th accepted byte: count wraps to 0, next state START.
REQ-020 START: enc_start=1 for exactly one cycle; next state WAIT.
REQ-021 enc_p_text held stable from START entry until enc_done sampled high.
REQ-022 WAIT: on enc_done=1 capture enc_c_text into out_data; next state OUTPUT; no timeout.
REQ-023 OUTPUT: out_valid=1, out_data stable until out_ready=1; then COLLECT next cycle.
REQ-024 in_ready=0 in START, WAIT, OUTPUT; in_valid ignored there.
REQ-025 enc_done outside WAIT ignored.
REQ-026 out_ready held high: OUTPUT lasts one cycle; first byte of next block accepted earliest one cycle later.
REQ-027 Throughput: 8 COLLECT cycles + START + encoder latency + 1 OUTPUT cycle minimum per block.

Reset
REQ-028 reset=0: state COLLECT, count 0, block register 0, chain register 0, out_data 0, enc_start 0, out_valid 0, in_ready 0 while asserted, busy 0.
REQ-029 Reset mid-operation discards partial block and pending ciphertext; encoder shares same reset net.

Configuration
REQ-030 Macro ENC_FEEDER_CBC_EN defined: enc_p_text = block ^ chain; chain <= enc_c_text on enc_done in WAIT.
REQ-031 With CBC: iv_load=1 in COLLECT at count 0 loads chain <= iv; simultaneous first byte still accepted; iv_load elsewhere ignored.
REQ-032 Macro undefined: enc_p_text = block register; iv, iv_load unused; no chain register.

Structure
REQ-033 Shared package holds BLOCK_LENGTH, byte count constant, FSM state encodings.
REQ-034 No sub-module; encoder instantiated by parent, not inside this block.

Verification
REQ-035 Bytes 01..08 back-to-back -> enc_p_text=0x0102030405060708, single enc_start pulse cycle after 8th byte.
REQ-036 enc_done with enc_c_text=0xDEADBEEFCAFEF00D, out_ready=0 for 5 cycles -> out_valid held, out_data stable; accepted cycle out_ready=1.
REQ-037 in_valid toggling 1,0,1 across 8 bytes -> assembly unaffected by gaps; in_valid during WAIT -> in_ready=0, no byte consumed.
REQ-038 Reset asserted after 4 bytes -> all outputs reset values; next 8 bytes form fresh block.
REQ-039 CBC_EN: iv=0xFFFFFFFFFFFFFFFF, iv_load, zero bytes -> enc_p_text=0xFFFFFFFFFFFFFFFF; second zero block -> enc_p_text = first enc_c_text.
REQ-040 Full loop with real encoder, key 0, plaintext 0 -> out_data matches golden model.

Source files
------------

// File: rtl/enc_block_feeder_pkg.sv
// Shared constants and FSM encoding for the cipher block feeder.
// Only a 64-bit cipher block is supported, which gives eight bytes per block.
package enc_block_feeder_pkg;

  localparam int BLOCK_LENGTH = 64;
  localparam int BYTE_COUNT   = BLOCK_LENGTH / 8;
  localparam int COUNT_W      = $clog2(BYTE_COUNT);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

endpackage

// File: rtl/enc_block_feeder_if.sv
// Byte input, encoder handshake and ciphertext output of the block feeder.
// The master modport is the feeder itself; the slave modport is its environment.
interface enc_block_feeder_if;
  import enc_block_feeder_pkg::*;

  logic                    in_valid;
  logic [7:0]              in_byte;
  logic                    in_ready;
  logic                    iv_load;
  logic [BLOCK_LENGTH-1:0] iv;
  logic                    enc_start;
  logic [BLOCK_LENGTH-1:0] enc_p_text;
  logic                    enc_done;
  logic [BLOCK_LENGTH-1:0] enc_c_text;
  logic                    out_valid;
  logic [BLOCK_LENGTH-1:0] out_data;
  logic                    out_ready;
  logic                    busy;

  modport master (
    input  in_valid, in_byte, iv_load, iv, enc_done, enc_c_text, out_ready,
    output in_ready, enc_start, enc_p_text, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_byte, iv_load, iv, enc_done, enc_c_text, out_ready,
    input  in_ready, enc_start, enc_p_text, out_valid, out_data, busy
  );

endinterface

// File: rtl/enc_block_feeder.sv
// Packs an MSB-first byte stream into 64-bit blocks, hands each to an external
// encoder and holds the ciphertext until taken. Define ENC_FEEDER_CBC_EN for CBC chaining.
module enc_block_feeder
  import enc_block_feeder_pkg::*;
#(
  parameter int BLOCK_LENGTH = enc_block_feeder_pkg::BLOCK_LENGTH
) (
  input  logic               clk,
  input  logic               reset,
  enc_block_feeder_if.master bus
);

  state_t                  state;
  logic [COUNT_W-1:0]      count;
  logic [BLOCK_LENGTH-1:0] block_q;
  logic [BLOCK_LENGTH-1:0] out_data_q;
  logic                    in_ready_q;
  logic                    enc_start_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    accept;

  assign accept = bus.in_valid && in_ready_q;

`ifdef ENC_FEEDER_CBC_EN
  logic [BLOCK_LENGTH-1:0] chain_q;

  // Block and chain only change in COLLECT / on leaving WAIT, so this stays stable for the encoder.
  assign bus.enc_p_text = block_q ^ chain_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
    end else if (state == COLLECT && count == '0 && bus.iv_load) begin
      chain_q <= bus.iv;
    end else if (state == WAIT && bus.enc_done) begin
      chain_q <= bus.enc_c_text;
    end
  end
`else
  logic unused_cbc;

  assign bus.enc_p_text = block_q;
  assign unused_cbc     = ^{bus.iv_load, bus.iv};
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.enc_start = enc_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      count       <= '0;
      block_q     <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      enc_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      enc_start_q <= 1'b0;
      unique case (state)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            for (int i = 0; i < BYTE_COUNT; i++) begin
              if (count == COUNT_W'(i)) begin
                block_q[(BYTE_COUNT-1-i)*8 +: 8] <= bus.in_byte;
              end
            end
            count <= count + 1'b1;
            if (count == COUNT_W'(BYTE_COUNT-1)) begin
              state       <= START;
              in_ready_q  <= 1'b0;
              enc_start_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.enc_done) begin
            out_data_q  <= bus.enc_c_text;
            out_valid_q <= 1'b1;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_block_feeder.sv
// Directed, table-driven bench for enc_block_feeder, with a stand-in encoder
// for the closed-loop case. Build with ENC_FEEDER_CBC_EN to exercise chaining.
module tb_enc_block_feeder;
  import enc_block_feeder_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  enc_block_feeder_if bus ();

  enc_block_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [0:7][7:0] bytes;
    logic [7:0]      gaps;
    logic            iv_load;
    logic [63:0]     exp_block;
    logic [63:0]     c_text;
    logic            use_model;
    int              wait_cycles;
    int              hold;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] chain_m = '0;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in for the external encoder: any fixed keyed bijection serves here.
  function automatic logic [63:0] enc_model(input logic [63:0] p, input logic [63:0] key);
    logic [63:0] x;
    x = p ^ key;
    for (int r = 0; r < 4; r++) begin
      x = ({x[50:0], x[63:51]} ^ 64'h9E37_79B9_7F4A_7C15) + key;
    end
    return x;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},   64'(bus.in_ready),  64'd0);
    check({tag, " enc_start"},  64'(bus.enc_start), 64'd0);
    check({tag, " out_valid"},  64'(bus.out_valid), 64'd0);
    check({tag, " busy"},       64'(bus.busy),      64'd0);
    check({tag, " out_data"},   bus.out_data,       64'd0);
    check({tag, " enc_p_text"}, bus.enc_p_text,     64'd0);
  endtask

  task automatic send_bytes(input logic [0:7][7:0] b, input logic [7:0] gaps,
                            input logic iv_load, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (gaps[k]) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_byte  = b[k];
      bus.iv_load  = iv_load && (k == 0);
      for (int t = 0; t < 20 && !bus.in_ready; t++) tick();
      if (!bus.in_ready) begin
        check({tag, " in_ready timeout"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        bus.iv_load  = 1'b0;
        return;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.iv_load  = 1'b0;
  endtask

  task automatic run_block(input vec_t v, input string tag);
    logic [63:0] exp_p;
    logic [63:0] exp_out;
    logic [63:0] c;
`ifdef ENC_FEEDER_CBC_EN
    if (v.iv_load) chain_m = bus.iv;
`endif
    exp_p   = v.exp_block ^ chain_m;
    exp_out = v.use_model ? enc_model(exp_p, 64'd0) : v.c_text;

    send_bytes(v.bytes, v.gaps, v.iv_load, 8, tag);
    check({tag, " enc_start"},  64'(bus.enc_start), 64'd1);
    check({tag, " enc_p_text"}, bus.enc_p_text,     exp_p);
    check({tag, " busy start"}, 64'(bus.busy),      64'd1);
    check({tag, " in_ready start"}, 64'(bus.in_ready), 64'd0);

    // WAIT: a byte offered now must be refused and not consumed.
    tick();
    check({tag, " enc_start pulse"}, 64'(bus.enc_start), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hEE;
    for (int i = 0; i < v.wait_cycles; i++) begin
      tick();
      check({tag, " in_ready wait"}, 64'(bus.in_ready),  64'd0);
      check({tag, " out_valid wait"}, 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    check({tag, " enc_p_text hold"}, bus.enc_p_text, exp_p);

    c = v.use_model ? enc_model(bus.enc_p_text, 64'd0) : v.c_text;
    bus.enc_c_text = c;
    bus.enc_done   = 1'b1;
    tick();
    bus.enc_done   = 1'b0;
    bus.enc_c_text = ~c;
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " out_data"},  bus.out_data,        exp_out);

    // Stray enc_done during OUTPUT must not disturb the held ciphertext.
    for (int i = 0; i < v.hold; i++) begin
      bus.enc_done = 1'b1;
      tick();
      check({tag, " out_valid held"}, 64'(bus.out_valid), 64'd1);
      check({tag, " out_data held"},  bus.out_data,        exp_out);
    end
    bus.enc_done  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, " busy drop"},      64'(bus.busy),      64'd0);
    check({tag, " in_ready back"},  64'(bus.in_ready),  64'd1);
`ifdef ENC_FEEDER_CBC_EN
    chain_m = exp_out;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{bytes: 64'h0102_0304_0506_0708, gaps: 8'h00, iv_load: 1'b0,
                exp_block: 64'h0102_0304_0506_0708, c_text: 64'hDEAD_BEEF_CAFE_F00D,
                use_model: 1'b0, wait_cycles: 1, hold: 5};
    vecs[1] = '{bytes: 64'h0102_0304_0506_0708, gaps: 8'hAA, iv_load: 1'b0,
                exp_block: 64'h0102_0304_0506_0708, c_text: 64'h0123_4567_89AB_CDEF,
                use_model: 1'b0, wait_cycles: 3, hold: 0};
    vecs[2] = '{bytes: 64'hFF00_8001_7EA5_5AC3, gaps: 8'h01, iv_load: 1'b0,
                exp_block: 64'hFF00_8001_7EA5_5AC3, c_text: 64'h0000_0000_0000_0000,
                use_model: 1'b0, wait_cycles: 1, hold: 1};
    vecs[3] = '{bytes: 64'h1122_3344_5566_7788, gaps: 8'hFF, iv_load: 1'b0,
                exp_block: 64'h1122_3344_5566_7788, c_text: 64'hFEDC_BA98_7654_3210,
                use_model: 1'b0, wait_cycles: 2, hold: 2};
    vecs[4] = '{bytes: 64'h0, gaps: 8'h00, iv_load: 1'b0,
                exp_block: 64'h0, c_text: 64'h0,
                use_model: 1'b1, wait_cycles: 4, hold: 0};

    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_byte    = '0;
    bus.iv_load    = 1'b0;
    bus.iv         = '0;
    bus.enc_done   = 1'b0;
    bus.enc_c_text = '0;
    bus.out_ready  = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset after four bytes: partial block and last ciphertext are discarded.
    send_bytes(64'hA1A2_A3A4_0000_0000, 8'h00, 1'b0, 4, "partial");
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    tick();
    reset   = 1'b1;
    chain_m = '0;
    tick();
    run_block('{bytes: 64'hB1B2_B3B4_B5B6_B7B8, gaps: 8'h00, iv_load: 1'b0,
                exp_block: 64'hB1B2_B3B4_B5B6_B7B8, c_text: 64'h5555_AAAA_5555_AAAA,
                use_model: 1'b0, wait_cycles: 1, hold: 0}, "fresh");

`ifdef ENC_FEEDER_CBC_EN
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    chain_m = '0;
    tick();
    bus.iv = 64'hFFFF_FFFF_FFFF_FFFF;
    run_block('{bytes: 64'h0, gaps: 8'h00, iv_load: 1'b1,
                exp_block: 64'h0, c_text: 64'h1234_5678_9ABC_DEF0,
                use_model: 1'b0, wait_cycles: 1, hold: 0}, "cbc iv");
    check("cbc chain model", chain_m, 64'h1234_5678_9ABC_DEF0);
    run_block('{bytes: 64'h0, gaps: 8'h00, iv_load: 1'b0,
                exp_block: 64'h0, c_text: 64'h0F0F_0F0F_0F0F_0F0F,
                use_model: 1'b0, wait_cycles: 1, hold: 0}, "cbc chain");
    run_block('{bytes: 64'h0, gaps: 8'h00, iv_load: 1'b0,
                exp_block: 64'h0, c_text: 64'h0,
                use_model: 1'b1, wait_cycles: 3, hold: 1}, "cbc loop");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
